// File: rtl/m_cascade_counter_pkg.sv
// Package: m_cascade_counter_pkg
// Purpose : Definitions shared by the cascaded modulo counter: count direction
//           encoding, default geometry and the helper that turns a run-time
//           modulus ("law") into the highest legal digit value.
// Contents:
//   DEFAULT_WIDTH, DEFAULT_NUM_STAGES  default digit width and stage count
//   dir_e                              DIR_UP = 0, DIR_DOWN = 1
//   mod_minus_one(law, width)          (effective modulus - 1) in `width` bits
package m_cascade_counter_pkg;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_NUM_STAGES = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // law == 0 selects the full 2^width range. Subtracting one and masking to
  // `width` bits yields all ones for that case, and law-1 otherwise, so no
  // special-casing is needed. Valid for width < 32.
  function automatic logic [31:0] mod_minus_one(input logic [31:0] law,
                                                input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (law - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/m_cascade_counter_if.sv
// Interface: m_cascade_counter_if
// Purpose  : Control and result bundle of the cascaded modulo counter.
// Signals (packing: stage i at [i*WIDTH +: WIDTH]):
//   en        count enable for stage 0 (advance request)
//   dir       0 = count up, 1 = count down
//   load      synchronous load of load_val into every stage
//   load_val  load value per stage
//   law       modulus per stage (0 = full 2^WIDTH range)
//   q         current count per stage (registered)
//   countup   per-stage wrap/borrow pulse (registered)
//   wrap      whole chain wrapped (registered)
// Modports: master drives the controls, slave is the counter itself.
interface m_cascade_counter_if #(
  parameter int WIDTH      = 4,
  parameter int NUM_STAGES = 2
);

  logic                        en;
  logic                        dir;
  logic                        load;
  logic [NUM_STAGES*WIDTH-1:0] load_val;
  logic [NUM_STAGES*WIDTH-1:0] law;
  logic [NUM_STAGES*WIDTH-1:0] q;
  logic [NUM_STAGES-1:0]       countup;
  logic                        wrap;

  modport master (
    output en, dir, load, load_val, law,
    input  q, countup, wrap
  );

  modport slave (
    input  en, dir, load, load_val, law,
    output q, countup, wrap
  );

endinterface

// File: rtl/m_cascade_counter_mod_stage.sv
// Module : m_mod_stage
// Purpose: One digit of the cascaded counter. Counts modulo its run-time law
//          when `adv` is high, in the direction given by `dir`.
// Ports:
//   ck        clock
//   res       synchronous active-high reset
//   load      synchronous load of load_val (overrides adv)
//   load_val  value loaded as given, no range clipping
//   law       modulus (0 = full 2^WIDTH range)
//   adv       advance this digit on the coming edge
//   dir       0 = up, 1 = down
//   q         current digit value (registered)
//   term      combinational terminal flag from current q / law / dir
//   countup   one-cycle pulse in the cycle q shows the wrapped value
module m_mod_stage
  import m_cascade_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             ck,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] law,
  input  logic             adv,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             term,
  output logic             countup
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             countup_reg;
  logic             countup_next;
  logic [WIDTH-1:0] last_val;
  logic             in_range;
  dir_e             dir_s;

  assign dir_s    = dir_e'(dir);
  assign last_val = WIDTH'(mod_minus_one(32'(law), WIDTH));
  assign in_range = (q_reg <= last_val);

  // Counting up, anything at or beyond the last legal value is terminal, so an
  // out-of-range digit (after a load or law change) wraps to 0 and carries.
  // Counting down, only 0 borrows.
  always_comb begin
    term = 1'b0;
    if (dir_s == DIR_UP) begin
      term = (q_reg >= last_val);
    end else begin
      term = (q_reg == '0);
    end
  end

  always_comb begin
    q_next       = q_reg;
    countup_next = 1'b0;
    if (adv) begin
      countup_next = term;
      if (term) begin
        q_next = (dir_s == DIR_UP) ? '0 : last_val;
      end else if (dir_s == DIR_UP) begin
        q_next = q_reg + 1'b1;
      end else if (in_range) begin
        q_next = q_reg - 1'b1;
      end else begin
        // Out-of-range digit counting down snaps to the top legal value
        // without borrowing.
        q_next = last_val;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (res) begin
      q_reg       <= '0;
      countup_reg <= 1'b0;
    end else if (load) begin
      q_reg       <= load_val;
      countup_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      countup_reg <= countup_next;
    end
  end

  assign q       = q_reg;
  assign countup = countup_reg;

endmodule

// File: rtl/m_cascade_counter.sv
// Module : m_cascade_counter
// Purpose: NUM_STAGES cascaded modulo digits of WIDTH bits each. Stage i
//          advances only when every lower stage is terminal on the same edge;
//          all stages share one clock (no ripple clocking).
// Ports:
//   ck   clock
//   res  synchronous active-high reset (overrides load and en)
//   bus  m_cascade_counter_if.slave: en, dir, load, load_val, law in;
//        q, countup, wrap out (all outputs registered)
module m_cascade_counter
  import m_cascade_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                 ck,
  input  logic                 res,
  m_cascade_counter_if.slave   bus
);

  // adv[i] is the advance request into stage i; adv[NUM_STAGES] is the carry
  // out of the top stage, i.e. the whole chain wrapping on this edge.
  logic [NUM_STAGES:0]         adv;
  logic [NUM_STAGES-1:0]       term;
  logic [NUM_STAGES-1:0]       countup_w;
  logic [NUM_STAGES*WIDTH-1:0] q_w;
  logic                        wrap_reg;

  assign adv[0] = bus.en;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    m_mod_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .ck       (ck),
      .res      (res),
      .load     (bus.load),
      .load_val (bus.load_val[gi*WIDTH +: WIDTH]),
      .law      (bus.law[gi*WIDTH +: WIDTH]),
      .adv      (adv[gi]),
      .dir      (bus.dir),
      .q        (q_w[gi*WIDTH +: WIDTH]),
      .term     (term[gi]),
      .countup  (countup_w[gi])
    );

    assign adv[gi+1] = adv[gi] & term[gi];
  end

  always_ff @(posedge ck) begin
    if (res) begin
      wrap_reg <= 1'b0;
    end else if (bus.load) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= adv[NUM_STAGES];
    end
  end

  assign bus.q       = q_w;
  assign bus.countup = countup_w;
  assign bus.wrap    = wrap_reg;

endmodule

// File: tb/tb_m_cascade_counter.sv
// Testbench for m_cascade_counter (WIDTH=4, NUM_STAGES=2). Directed scenarios
// check hand-derived values; a randomized run checks against a digit-level
// integer model of the counting rules.
module tb_m_cascade_counter;

  localparam int W = 4;
  localparam int N = 2;

  logic ck = 1'b0;
  logic res;

  always #5 ck = ~ck;

  m_cascade_counter_if #(.WIDTH(W), .NUM_STAGES(N)) bus ();

  m_cascade_counter #(
    .WIDTH      (W),
    .NUM_STAGES (N)
  ) dut (
    .ck  (ck),
    .res (res),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Inputs as applied for the coming edge (bench's own copy).
  bit         c_res, c_load, c_en, c_dir;
  logic [7:0] c_lv, c_law;

  // Reference model state.
  int m_q [N];
  int m_cu[N];
  int m_wrap;

  function automatic logic [7:0] model_q();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_q[i]);
    return v;
  endfunction

  function automatic logic [1:0] model_cu();
    logic [1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_cu[i] != 0);
    return v;
  endfunction

  // One clock edge of the counting rules, on plain integers.
  task automatic model_step();
    int adv, m, carry;
    if (c_res) begin
      for (int i = 0; i < N; i++) begin m_q[i] = 0; m_cu[i] = 0; end
      m_wrap = 0;
    end else if (c_load) begin
      for (int i = 0; i < N; i++) begin m_q[i] = int'(c_lv[i*W +: W]); m_cu[i] = 0; end
      m_wrap = 0;
    end else begin
      adv = c_en ? 1 : 0;
      for (int i = 0; i < N; i++) begin
        m = int'(c_law[i*W +: W]);
        if (m == 0) m = 1 << W;
        carry = 0;
        if (adv != 0) begin
          if (!c_dir) begin
            if (m_q[i] >= m - 1) begin m_q[i] = 0; carry = 1; end
            else m_q[i] = m_q[i] + 1;
          end else begin
            if (m_q[i] == 0) begin m_q[i] = m - 1; carry = 1; end
            else if (m_q[i] >= m) m_q[i] = m - 1;
            else m_q[i] = m_q[i] - 1;
          end
        end
        m_cu[i] = carry;
        adv = carry;
      end
      m_wrap = adv;
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit d,
                       input logic [7:0] lv, input logic [7:0] lw);
    c_res = r; c_load = l; c_en = e; c_dir = d; c_lv = lv; c_law = lw;
    res          = r;
    bus.load     = l;
    bus.en       = e;
    bus.dir      = d;
    bus.load_val = lv;
    bus.law      = lw;
  endtask

  // Apply the driven inputs on one edge, advance the model, sample at +1.
  task automatic tick();
    @(posedge ck);
    model_step();
    #1;
    $display("t=%0t res=%0b load=%0b en=%0b dir=%0b law=%h lv=%h -> q=%h countup=%b wrap=%0b",
             $time, c_res, c_load, c_en, c_dir, c_law, c_lv, bus.q, bus.countup, bus.wrap);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 8'(($urandom_range(1, 255))), 8'h6A);
    tick();
    n_cmp++;
    if (bus.q !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b00) begin n_bad++; $display("FAIL reset_countup: got %b want 00", bus.countup); end
    n_cmp++;
    if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", bus.wrap); end
  endtask

  task automatic test_up_decade();
    drive(1, 0, 0, 0, 8'h00, 8'h6A);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 1, 0, 8'h00, 8'h6A);
      tick();
      n_cmp++;
      if (bus.q !== {4'(k / 10), 4'(k % 10)}) begin
        n_bad++; $display("FAIL up_decade_q k=%0d: got %h want %h", k, bus.q, {4'(k / 10), 4'(k % 10)});
      end
      n_cmp++;
      if (bus.countup !== {1'b0, (k == 10)}) begin
        n_bad++; $display("FAIL up_decade_countup k=%0d: got %b want %b", k, bus.countup, {1'b0, (k == 10)});
      end
    end
  endtask

  task automatic test_full_cycle();
    int wraps;
    logic [7:0] exp_q;
    logic [1:0] exp_cu;
    wraps = 0;
    drive(1, 0, 0, 0, 8'h00, 8'h6A);
    tick();
    for (int k = 1; k <= 61; k++) begin
      drive(0, 0, 1, 0, 8'h00, 8'h6A);
      tick();
      exp_q  = {4'((k / 10) % 6), 4'(k % 10)};
      exp_cu = {(k % 60 == 0), (k % 10 == 0)};
      if (bus.wrap === 1'b1) wraps++;
      n_cmp++;
      if (bus.q !== exp_q) begin n_bad++; $display("FAIL full_q k=%0d: got %h want %h", k, bus.q, exp_q); end
      n_cmp++;
      if (bus.countup !== exp_cu) begin n_bad++; $display("FAIL full_countup k=%0d: got %b want %b", k, bus.countup, exp_cu); end
      n_cmp++;
      if (bus.wrap !== (k == 60)) begin n_bad++; $display("FAIL full_wrap k=%0d: got %b want %b", k, bus.wrap, (k == 60)); end
    end
    n_cmp++;
    if (wraps != 1) begin n_bad++; $display("FAIL full_wrap_count: got %0d want 1", wraps); end
  endtask

  task automatic test_down();
    drive(1, 0, 0, 0, 8'h00, 8'h6A);
    tick();
    drive(0, 0, 1, 1, 8'h00, 8'h6A);
    tick();
    n_cmp++;
    if (bus.q !== 8'h59) begin n_bad++; $display("FAIL down_borrow_q: got %h want 59", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b11) begin n_bad++; $display("FAIL down_borrow_countup: got %b want 11", bus.countup); end
    n_cmp++;
    if (bus.wrap !== 1'b1) begin n_bad++; $display("FAIL down_borrow_wrap: got %b want 1", bus.wrap); end
    tick();
    n_cmp++;
    if (bus.q !== 8'h58) begin n_bad++; $display("FAIL down_next_q: got %h want 58", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b00) begin n_bad++; $display("FAIL down_next_countup: got %b want 00", bus.countup); end
    n_cmp++;
    if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL down_next_wrap: got %b want 0", bus.wrap); end
  endtask

  task automatic test_out_of_range();
    // load wins over en
    drive(0, 1, 1, 0, 8'h1C, 8'h6A);
    tick();
    n_cmp++;
    if (bus.q !== 8'h1C) begin n_bad++; $display("FAIL oor_load_q: got %h want 1C", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b00) begin n_bad++; $display("FAIL oor_load_countup: got %b want 00", bus.countup); end
    drive(0, 0, 1, 0, 8'h00, 8'h6A);
    tick();
    n_cmp++;
    if (bus.q !== 8'h20) begin n_bad++; $display("FAIL oor_up_q: got %h want 20", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b01) begin n_bad++; $display("FAIL oor_up_countup: got %b want 01", bus.countup); end
    drive(0, 1, 0, 0, 8'h1C, 8'h6A);
    tick();
    drive(0, 0, 1, 1, 8'h00, 8'h6A);
    tick();
    n_cmp++;
    if (bus.q !== 8'h19) begin n_bad++; $display("FAIL oor_down_q: got %h want 19", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b00) begin n_bad++; $display("FAIL oor_down_countup: got %b want 00", bus.countup); end
  endtask

  task automatic test_full_range();
    drive(0, 1, 0, 0, 8'h0F, 8'h60);
    tick();
    drive(0, 0, 1, 0, 8'h00, 8'h60);
    tick();
    n_cmp++;
    if (bus.q !== 8'h10) begin n_bad++; $display("FAIL fullrange_q: got %h want 10", bus.q); end
    n_cmp++;
    if (bus.countup !== 2'b01) begin n_bad++; $display("FAIL fullrange_countup: got %b want 01", bus.countup); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, (k % 2) == 1, 0, 8'h00, 8'h60);
      tick();
      n_cmp++;
      if (bus.q !== (8'h10 + 8'(k / 2 + k % 2))) begin
        n_bad++; $display("FAIL fullrange_toggle_q k=%0d: got %h want %h", k, bus.q, 8'h10 + 8'(k / 2 + k % 2));
      end
      n_cmp++;
      if (bus.countup !== 2'b00) begin n_bad++; $display("FAIL fullrange_toggle_countup k=%0d: got %b want 00", k, bus.countup); end
    end
  endtask

  task automatic test_random();
    logic [7:0] lw;
    bit d;
    lw = 8'h32;
    d  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        lw[3:0] = 4'($urandom_range(0, 5));
        lw[7:4] = 4'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 15) == 0) d = ~d;
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) != 0, d, 8'($urandom_range(0, 255)), lw);
      tick();
      n_cmp++;
      if (bus.q !== model_q()) begin n_bad++; $display("FAIL rand_q k=%0d: got %h want %h", k, bus.q, model_q()); end
      n_cmp++;
      if (bus.countup !== model_cu()) begin n_bad++; $display("FAIL rand_countup k=%0d: got %b want %b", k, bus.countup, model_cu()); end
      n_cmp++;
      if (bus.wrap !== (m_wrap != 0)) begin n_bad++; $display("FAIL rand_wrap k=%0d: got %b want %b", k, bus.wrap, (m_wrap != 0)); end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 8'h00, 8'h6A);
    #2;
    test_reset();
    test_up_decade();
    test_full_cycle();
    test_down();
    test_out_of_range();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
